// File: rtl/bus_drvr_fifo_pair_if.sv
// Driver-side bundle between the bus arbiter, the device and the TX/RX FIFO pair.
// The slave modport is the FIFO pair itself; master is the arbiter/device side.
interface bus_drvr_fifo_pair_if #(
  parameter int bits  = 256,
  parameter int depth = 8
);
  localparam int CW = $clog2(depth) + 1;

  // arbiter side
  logic            pndng;
  logic            pop;
  logic [bits-1:0] D_pop;
  logic            push;
  logic [bits-1:0] D_push;

  // device side
  logic            dev_push;
  logic [bits-1:0] dev_D_push;
  logic            dev_full;
  logic            dev_pop;
  logic [bits-1:0] dev_D_pop;
  logic            dev_pndng;

  // status and error reporting
  logic [CW-1:0]   tx_count;
  logic [CW-1:0]   rx_count;
  logic            err_clr;
  logic            tx_ovf;
  logic            tx_unf;
  logic            rx_ovf;
  logic            rx_unf;
  logic [7:0]      rx_drop_cnt;

  modport master (
    output pop, push, D_push, dev_push, dev_D_push, dev_pop, err_clr,
    input  pndng, D_pop, dev_full, dev_D_pop, dev_pndng,
    input  tx_count, rx_count, tx_ovf, tx_unf, rx_ovf, rx_unf, rx_drop_cnt
  );

  modport slave (
    input  pop, push, D_push, dev_push, dev_D_push, dev_pop, err_clr,
    output pndng, D_pop, dev_full, dev_D_pop, dev_pndng,
    output tx_count, rx_count, tx_ovf, tx_unf, rx_ovf, rx_unf, rx_drop_cnt
  );
endinterface

// File: rtl/bus_drvr_fifo_pair.sv
// Bus driver FIFO pair: TX path (device -> arbiter) and RX path (arbiter -> device).
// Both FIFOs are first-word-fall-through; the head is shown combinationally and
// forced to zero while empty. The two paths share only clk, reset and err_clr.
module bus_drvr_fifo_pair #(
  parameter int bits  = 256,
  parameter int depth = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_drvr_fifo_pair_if.slave  bus
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  // TX path state
  logic [bits-1:0] tx_mem_q [depth];
  logic [bits-1:0] tx_mem_d [depth];
  logic [AW-1:0]   tx_wptr_q, tx_wptr_d;
  logic [AW-1:0]   tx_rptr_q, tx_rptr_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
  logic            tx_ovf_q, tx_ovf_d;
  logic            tx_unf_q, tx_unf_d;
  logic            tx_wr_ok, tx_rd_ok;

  // RX path state
  logic [bits-1:0] rx_mem_q [depth];
  logic [bits-1:0] rx_mem_d [depth];
  logic [AW-1:0]   rx_wptr_q, rx_wptr_d;
  logic [AW-1:0]   rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic            rx_ovf_q, rx_ovf_d;
  logic            rx_unf_q, rx_unf_d;
  logic [7:0]      rx_drop_q, rx_drop_d;
  logic [7:0]      rx_drop_base;
  logic            rx_wr_ok, rx_rd_ok;

  // TX next state: a pop frees a slot in the same cycle, so write-while-full
  // is accepted when it coincides with a pop.
  always_comb begin
    tx_rd_ok  = bus.pop && (tx_cnt_q != '0);
    tx_wr_ok  = bus.dev_push && ((tx_cnt_q != FULL_CNT) || tx_rd_ok);
    tx_mem_d  = tx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_wr_ok) begin
      tx_mem_d[tx_wptr_q] = bus.dev_D_push;
      tx_wptr_d           = tx_wptr_q + 1'b1;
    end
    if (tx_rd_ok) begin
      tx_rptr_d = tx_rptr_q + 1'b1;
    end
    case ({tx_wr_ok, tx_rd_ok})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
    tx_ovf_d = bus.err_clr ? 1'b0 : tx_ovf_q;
    tx_unf_d = bus.err_clr ? 1'b0 : tx_unf_q;
    if (bus.dev_push && !tx_wr_ok) begin
      tx_ovf_d = 1'b1;
    end
    if (bus.pop && (tx_cnt_q == '0)) begin
      tx_unf_d = 1'b1;
    end
  end

  // RX next state: same rules as TX, plus a saturating drop counter whose
  // clear loses to a drop in the same cycle.
  always_comb begin
    rx_rd_ok  = bus.dev_pop && (rx_cnt_q != '0);
    rx_wr_ok  = bus.push && ((rx_cnt_q != FULL_CNT) || rx_rd_ok);
    rx_mem_d  = rx_mem_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_wr_ok) begin
      rx_mem_d[rx_wptr_q] = bus.D_push;
      rx_wptr_d           = rx_wptr_q + 1'b1;
    end
    if (rx_rd_ok) begin
      rx_rptr_d = rx_rptr_q + 1'b1;
    end
    case ({rx_wr_ok, rx_rd_ok})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    rx_ovf_d     = bus.err_clr ? 1'b0 : rx_ovf_q;
    rx_unf_d     = bus.err_clr ? 1'b0 : rx_unf_q;
    rx_drop_base = bus.err_clr ? 8'd0 : rx_drop_q;
    rx_drop_d    = rx_drop_base;
    if (bus.push && !rx_wr_ok) begin
      rx_ovf_d  = 1'b1;
      rx_drop_d = (rx_drop_base == 8'hFF) ? 8'hFF : rx_drop_base + 8'd1;
    end
    if (bus.dev_pop && (rx_cnt_q == '0)) begin
      rx_unf_d = 1'b1;
    end
  end

  // Control state: pointers, occupancy and error flags; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      tx_unf_q  <= 1'b0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      rx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
      rx_drop_q <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      tx_unf_q  <= tx_unf_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_ovf_q  <= rx_ovf_d;
      rx_unf_q  <= rx_unf_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  // Packet storage is left out of reset; stale entries are masked by the counts.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  // Head and status outputs: FWFT heads read straight from storage, zero when empty.
  always_comb begin
    bus.pndng       = (tx_cnt_q != '0);
    bus.D_pop       = (tx_cnt_q != '0) ? tx_mem_q[tx_rptr_q] : '0;
    bus.dev_full    = (tx_cnt_q == FULL_CNT);
    bus.dev_pndng   = (rx_cnt_q != '0);
    bus.dev_D_pop   = (rx_cnt_q != '0) ? rx_mem_q[rx_rptr_q] : '0;
    bus.tx_count    = tx_cnt_q;
    bus.rx_count    = rx_cnt_q;
    bus.tx_ovf      = tx_ovf_q;
    bus.tx_unf      = tx_unf_q;
    bus.rx_ovf      = rx_ovf_q;
    bus.rx_unf      = rx_unf_q;
    bus.rx_drop_cnt = rx_drop_q;
  end
endmodule

// File: tb/tb_bus_drvr_fifo_pair.sv
// Directed bench for bus_drvr_fifo_pair (bits=256, depth=8).
module tb_bus_drvr_fifo_pair;
  localparam int BITS  = 256;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  bus_drvr_fifo_pair_if #(.bits(BITS), .depth(DEPTH)) bus ();

  bus_drvr_fifo_pair #(.bits(BITS), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BITS-1:0] pat(input int i);
    pat = {8{32'h5A00_0000 | 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL reset_pndng got %b exp 0", bus.pndng); end
    n_checks++; if (bus.dev_pndng !== 1'b0) begin n_fail++; $display("FAIL reset_dev_pndng got %b exp 0", bus.dev_pndng); end
    n_checks++; if (bus.dev_full !== 1'b0) begin n_fail++; $display("FAIL reset_dev_full got %b exp 0", bus.dev_full); end
    n_checks++; if (bus.D_pop !== '0) begin n_fail++; $display("FAIL reset_D_pop got %h exp 0", bus.D_pop); end
    n_checks++; if (bus.dev_D_pop !== '0) begin n_fail++; $display("FAIL reset_dev_D_pop got %h exp 0", bus.dev_D_pop); end
    n_checks++; if ({bus.tx_count, bus.rx_count} !== 8'h00) begin n_fail++; $display("FAIL reset_counts got %h/%h exp 0/0", bus.tx_count, bus.rx_count); end
    n_checks++; if ({bus.tx_ovf, bus.tx_unf, bus.rx_ovf, bus.rx_unf} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {bus.tx_ovf, bus.tx_unf, bus.rx_ovf, bus.rx_unf}); end
    n_checks++; if (bus.rx_drop_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_drop got %0d exp 0", bus.rx_drop_cnt); end
  endtask

  task automatic test_tx_basic();
    logic [BITS-1:0] a1;
    a1 = '0;
    a1[7:0] = 8'hA1;
    bus.dev_push = 1'b1; bus.dev_D_push = a1;
    tick();
    bus.dev_push = 1'b0;
    n_checks++; if (bus.pndng !== 1'b1) begin n_fail++; $display("FAIL basic_pndng got %b exp 1", bus.pndng); end
    n_checks++; if (bus.D_pop !== a1) begin n_fail++; $display("FAIL basic_D_pop got %h exp %h", bus.D_pop, a1); end
    n_checks++; if (bus.tx_count !== 4'd1) begin n_fail++; $display("FAIL basic_tx_count got %0d exp 1", bus.tx_count); end
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    n_checks++; if (bus.pndng !== 1'b0) begin n_fail++; $display("FAIL basic_pop_pndng got %b exp 0", bus.pndng); end
    n_checks++; if (bus.D_pop !== '0) begin n_fail++; $display("FAIL basic_pop_D_pop got %h exp 0", bus.D_pop); end
    // two entries, then push and pop together in mid-occupancy
    for (int i = 1; i <= 2; i++) begin
      bus.dev_push = 1'b1; bus.dev_D_push = pat(i);
      tick();
    end
    bus.dev_D_push = pat(3); bus.pop = 1'b1;
    tick();
    bus.dev_push = 1'b0; bus.pop = 1'b0;
    n_checks++; if (bus.tx_count !== 4'd2) begin n_fail++; $display("FAIL mid_pushpop_count got %0d exp 2", bus.tx_count); end
    n_checks++; if (bus.D_pop !== pat(2)) begin n_fail++; $display("FAIL mid_pushpop_head got %h exp %h", bus.D_pop, pat(2)); end
    bus.pop = 1'b1;
    tick();
    n_checks++; if (bus.D_pop !== pat(3)) begin n_fail++; $display("FAIL mid_second_head got %h exp %h", bus.D_pop, pat(3)); end
    tick();
    n_checks++; if (bus.tx_unf !== 1'b0) begin n_fail++; $display("FAIL tx_unf_early got %b exp 0", bus.tx_unf); end
    tick();
    bus.pop = 1'b0;
    n_checks++; if ({bus.tx_unf, bus.pndng, bus.tx_count} !== 6'b1_0_0000) begin n_fail++; $display("FAIL tx_unf_empty got unf=%b pndng=%b cnt=%0d exp 1/0/0", bus.tx_unf, bus.pndng, bus.tx_count); end
    n_checks++; if (bus.rx_unf !== 1'b0) begin n_fail++; $display("FAIL tx_unf_leak_rx got %b exp 0", bus.rx_unf); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++; if (bus.tx_unf !== 1'b0) begin n_fail++; $display("FAIL tx_unf_clear got %b exp 0", bus.tx_unf); end
  endtask

  task automatic test_tx_full();
    for (int i = 1; i <= 8; i++) begin
      bus.dev_push = 1'b1; bus.dev_D_push = pat(i);
      tick();
    end
    bus.dev_push = 1'b0;
    n_checks++; if ({bus.dev_full, bus.tx_count} !== 5'b1_1000) begin n_fail++; $display("FAIL tx_full got full=%b cnt=%0d exp 1/8", bus.dev_full, bus.tx_count); end
    bus.dev_push = 1'b1; bus.dev_D_push = pat(99);
    tick();
    bus.dev_push = 1'b0;
    n_checks++; if ({bus.tx_ovf, bus.tx_count} !== 5'b1_1000) begin n_fail++; $display("FAIL tx_ovf got ovf=%b cnt=%0d exp 1/8", bus.tx_ovf, bus.tx_count); end
    n_checks++; if (bus.D_pop !== pat(1)) begin n_fail++; $display("FAIL tx_ovf_head got %h exp %h", bus.D_pop, pat(1)); end
    bus.dev_push = 1'b1; bus.dev_D_push = pat(9); bus.pop = 1'b1;
    tick();
    bus.dev_push = 1'b0; bus.pop = 1'b0;
    n_checks++; if ({bus.dev_full, bus.tx_count} !== 5'b1_1000) begin n_fail++; $display("FAIL tx_full_pushpop got full=%b cnt=%0d exp 1/8", bus.dev_full, bus.tx_count); end
    for (int i = 2; i <= 9; i++) begin
      n_checks++; if (bus.D_pop !== pat(i)) begin n_fail++; $display("FAIL tx_drain_%0d got %h exp %h", i, bus.D_pop, pat(i)); end
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
    end
    n_checks++; if ({bus.pndng, bus.tx_count} !== 5'b0_0000 || bus.D_pop !== '0) begin n_fail++; $display("FAIL tx_drained got pndng=%b cnt=%0d head=%h exp 0/0/0", bus.pndng, bus.tx_count, bus.D_pop); end
    n_checks++; if ({bus.rx_ovf, bus.rx_count} !== 5'b0_0000) begin n_fail++; $display("FAIL tx_leak_rx got ovf=%b cnt=%0d exp 0/0", bus.rx_ovf, bus.rx_count); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++; if (bus.tx_ovf !== 1'b0) begin n_fail++; $display("FAIL tx_ovf_clear got %b exp 0", bus.tx_ovf); end
  endtask

  task automatic test_rx_full();
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1'b1; bus.D_push = pat(10 + i);
      tick();
    end
    bus.push = 1'b0;
    n_checks++; if ({bus.dev_pndng, bus.rx_count} !== 5'b1_1000) begin n_fail++; $display("FAIL rx_fill got pndng=%b cnt=%0d exp 1/8", bus.dev_pndng, bus.rx_count); end
    bus.push = 1'b1; bus.D_push = pat(19); bus.dev_pop = 1'b1;
    tick();
    bus.push = 1'b0; bus.dev_pop = 1'b0;
    n_checks++; if ({bus.rx_count, bus.rx_drop_cnt, bus.rx_ovf} !== {4'd8, 8'd0, 1'b0}) begin n_fail++; $display("FAIL rx_full_pushpop got cnt=%0d drop=%0d ovf=%b exp 8/0/0", bus.rx_count, bus.rx_drop_cnt, bus.rx_ovf); end
    n_checks++; if (bus.dev_D_pop !== pat(12)) begin n_fail++; $display("FAIL rx_full_pushpop_head got %h exp %h", bus.dev_D_pop, pat(12)); end
    bus.push = 1'b1; bus.D_push = pat(20);
    tick();
    bus.push = 1'b0;
    n_checks++; if ({bus.rx_count, bus.rx_drop_cnt, bus.rx_ovf} !== {4'd8, 8'd1, 1'b1}) begin n_fail++; $display("FAIL rx_drop got cnt=%0d drop=%0d ovf=%b exp 8/1/1", bus.rx_count, bus.rx_drop_cnt, bus.rx_ovf); end
    for (int i = 12; i <= 19; i++) begin
      n_checks++; if (bus.dev_D_pop !== pat(i)) begin n_fail++; $display("FAIL rx_drain_%0d got %h exp %h", i, bus.dev_D_pop, pat(i)); end
      bus.dev_pop = 1'b1;
      tick();
      bus.dev_pop = 1'b0;
    end
    n_checks++; if ({bus.dev_pndng, bus.rx_count} !== 5'b0_0000 || bus.dev_D_pop !== '0) begin n_fail++; $display("FAIL rx_drained got pndng=%b cnt=%0d head=%h exp 0/0/0", bus.dev_pndng, bus.rx_count, bus.dev_D_pop); end
    n_checks++; if (bus.tx_ovf !== 1'b0) begin n_fail++; $display("FAIL rx_leak_tx got %b exp 0", bus.tx_ovf); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++; if ({bus.rx_drop_cnt, bus.rx_ovf} !== 9'd0) begin n_fail++; $display("FAIL rx_clear got drop=%0d ovf=%b exp 0/0", bus.rx_drop_cnt, bus.rx_ovf); end
  endtask

  task automatic test_rx_unf();
    bus.push = 1'b1; bus.D_push = pat(30); bus.dev_pop = 1'b1;
    tick();
    bus.push = 1'b0; bus.dev_pop = 1'b0;
    n_checks++; if ({bus.rx_unf, bus.rx_count} !== 5'b1_0001) begin n_fail++; $display("FAIL rx_unf got unf=%b cnt=%0d exp 1/1", bus.rx_unf, bus.rx_count); end
    n_checks++; if (bus.dev_D_pop !== pat(30)) begin n_fail++; $display("FAIL rx_unf_head got %h exp %h", bus.dev_D_pop, pat(30)); end
    bus.dev_pop = 1'b1;
    tick();
    bus.dev_pop = 1'b0;
    n_checks++; if ({bus.rx_unf, bus.rx_count} !== 5'b1_0000) begin n_fail++; $display("FAIL rx_unf_sticky got unf=%b cnt=%0d exp 1/0", bus.rx_unf, bus.rx_count); end
  endtask

  task automatic test_drop_sat();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1'b1; bus.D_push = pat(50 + i);
      tick();
    end
    bus.D_push = pat(66);
    for (int i = 0; i < 254; i++) tick();
    n_checks++; if (bus.rx_drop_cnt !== 8'd254) begin n_fail++; $display("FAIL drop_254 got %0d exp 254", bus.rx_drop_cnt); end
    for (int i = 0; i < 46; i++) tick();
    bus.push = 1'b0;
    n_checks++; if ({bus.rx_drop_cnt, bus.rx_count} !== {8'd255, 4'd8}) begin n_fail++; $display("FAIL drop_sat got drop=%0d cnt=%0d exp 255/8", bus.rx_drop_cnt, bus.rx_count); end
    n_checks++; if (bus.dev_D_pop !== pat(51)) begin n_fail++; $display("FAIL drop_head got %h exp %h", bus.dev_D_pop, pat(51)); end
    bus.err_clr = 1'b1;
    tick();
    n_checks++; if ({bus.rx_drop_cnt, bus.rx_ovf} !== 9'd0) begin n_fail++; $display("FAIL drop_clear got drop=%0d ovf=%b exp 0/0", bus.rx_drop_cnt, bus.rx_ovf); end
    bus.push = 1'b1;
    tick();
    bus.push = 1'b0; bus.err_clr = 1'b0;
    n_checks++; if ({bus.rx_drop_cnt, bus.rx_ovf} !== {8'd1, 1'b1}) begin n_fail++; $display("FAIL drop_clr_prio got drop=%0d ovf=%b exp 1/1", bus.rx_drop_cnt, bus.rx_ovf); end
  endtask

  task automatic test_mid_reset();
    // RX holds 51..58 with rx_ovf set; set tx_unf too
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus.dev_push = 1'b1; bus.dev_D_push = pat(20 + i);
      bus.dev_pop = (i <= 3);
      tick();
    end
    bus.dev_push = 1'b0; bus.dev_pop = 1'b0;
    n_checks++; if ({bus.tx_count, bus.rx_count} !== {4'd5, 4'd5}) begin n_fail++; $display("FAIL both_five got tx=%0d rx=%0d exp 5/5", bus.tx_count, bus.rx_count); end
    n_checks++; if (bus.D_pop !== pat(21) || bus.dev_D_pop !== pat(54)) begin n_fail++; $display("FAIL both_heads got %h / %h exp %h / %h", bus.D_pop, bus.dev_D_pop, pat(21), pat(54)); end
    n_checks++; if ({bus.tx_unf, bus.rx_ovf} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_flags got %b exp 11", {bus.tx_unf, bus.rx_ovf}); end
    reset = 1'b1;
    bus.dev_push = 1'b1; bus.dev_D_push = pat(70); bus.pop = 1'b1;
    bus.push = 1'b1; bus.D_push = pat(71); bus.dev_pop = 1'b1; bus.err_clr = 1'b1;
    tick();
    reset = 1'b0;
    bus.dev_push = 1'b0; bus.pop = 1'b0; bus.push = 1'b0; bus.dev_pop = 1'b0; bus.err_clr = 1'b0;
    n_checks++; if ({bus.tx_count, bus.rx_count} !== 8'h00) begin n_fail++; $display("FAIL mid_reset_counts got %0d/%0d exp 0/0", bus.tx_count, bus.rx_count); end
    n_checks++; if ({bus.tx_ovf, bus.tx_unf, bus.rx_ovf, bus.rx_unf, bus.rx_drop_cnt} !== 12'd0) begin n_fail++; $display("FAIL mid_reset_flags got %b drop=%0d exp 0000/0", {bus.tx_ovf, bus.tx_unf, bus.rx_ovf, bus.rx_unf}, bus.rx_drop_cnt); end
    n_checks++; if (bus.D_pop !== '0 || bus.dev_D_pop !== '0 || bus.pndng !== 1'b0 || bus.dev_pndng !== 1'b0) begin n_fail++; $display("FAIL mid_reset_heads got %h / %h exp 0 / 0", bus.D_pop, bus.dev_D_pop); end
    bus.dev_push = 1'b1; bus.dev_D_push = pat(77);
    bus.push = 1'b1; bus.D_push = pat(88);
    tick();
    bus.dev_push = 1'b0; bus.push = 1'b0;
    n_checks++; if (bus.D_pop !== pat(77) || bus.tx_count !== 4'd1) begin n_fail++; $display("FAIL post_reset_tx got %h cnt=%0d exp %h cnt=1", bus.D_pop, bus.tx_count, pat(77)); end
    n_checks++; if (bus.dev_D_pop !== pat(88) || bus.rx_count !== 4'd1) begin n_fail++; $display("FAIL post_reset_rx got %h cnt=%0d exp %h cnt=1", bus.dev_D_pop, bus.rx_count, pat(88)); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.pop = 1'b0; bus.push = 1'b0; bus.D_push = '0;
    bus.dev_push = 1'b0; bus.dev_D_push = '0; bus.dev_pop = 1'b0; bus.err_clr = 1'b0;
    #2;
    test_reset();
    test_tx_basic();
    test_tx_full();
    test_rx_full();
    test_rx_unf();
    test_drop_sat();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
